// File: rtl/stream_seq_check_pkg.sv
// Shared definitions for stream_seq_check: FSM state encoding, slot counter
// width and the saturating increment used by the error counter.
package stream_seq_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Four back-pressure slots, so the slot counter is two bits wide.
    localparam int SLOT_W = 2;

    // Increment that sticks at max_value. Operates on 32-bit values, so
    // callers with WIDTH up to 32 zero-extend in and truncate back out.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value == max_value) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/stream_seq_check_stall_gen.sv
// stream_stall_gen: back-pressure generator for stream_seq_check. A 2-bit
// slot counter walks the 4-bit pattern while the checker is running; the
// ready output depends only on registered state.
module stream_stall_gen
    import stream_seq_check_pkg::*;
#(
    parameter logic [3:0] PATTERN = 4'b1111
) (
    input  logic clk,
    input  logic nrst,
    input  logic run,
    input  logic restart,
    output logic ready
);

    logic [SLOT_W-1:0] slot;

    // Slot advances every running cycle, transfer or not; restart re-aligns it to slot 0.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            slot <= '0;
        end else if (restart) begin
            slot <= '0;
        end else if (run) begin
            slot <= slot + SLOT_W'(1);
        end
    end

    assign ready = run & PATTERN[slot];

endmodule

// File: rtl/stream_seq_check.sv
// stream_seq_check: stream sink that consumes COUNT items, checks them against
// an incrementing sequence starting at 'first', and reports count, error count
// and the last bad value through a valid/ready result handshake.
// Optional build macro: STREAM_SEQ_CHECK_RESYNC_EN -- on a mismatch the
// reference re-locks to the received value, so a slip costs a single error.
module stream_seq_check
    import stream_seq_check_pkg::*;
#(
    parameter int         WIDTH         = 8,
    parameter int         COUNT         = 16,
    parameter logic [3:0] STALL_PATTERN = 4'b1111
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] first,
    input  logic [WIDTH-1:0] sIn,
    input  logic             sIn_valid,
    output logic             sIn_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] errors,
    output logic [WIDTH-1:0] last_bad
);

    // Count value at which the final handshake of a run occurs (wraps when COUNT == 2^WIDTH).
    localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(COUNT - 1);
    localparam logic [WIDTH-1:0] ERR_MAX  = '1;

    state_t           state;
    logic [WIDTH-1:0] expected;
    logic [WIDTH-1:0] next_expected;
    logic             running;
    logic             start;
    logic             handshake;
    logic             mismatch;

    assign running   = (state == RUN);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign start     = in_valid && (state == IDLE);
    assign handshake = sIn_valid && sIn_ready;
    assign mismatch  = (sIn != expected);

`ifdef STREAM_SEQ_CHECK_RESYNC_EN
    assign next_expected = mismatch ? sIn + WIDTH'(1) : expected + WIDTH'(1);
`else
    assign next_expected = expected + WIDTH'(1);
`endif

    stream_stall_gen #(
        .PATTERN (STALL_PATTERN)
    ) u_stall_gen (
        .clk     (clk),
        .nrst    (nrst),
        .run     (running),
        .restart (start),
        .ready   (sIn_ready)
    );

    // Run FSM with comparator and result counters; results persist until the next start.
    // NOTE: every register here is assigned with <= so all updates see pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            expected <= '0;
            count    <= '0;
            errors   <= '0;
            last_bad <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        expected <= first;
                        count    <= '0;
                        errors   <= '0;
                        last_bad <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (handshake) begin
                        if (mismatch) begin
                            errors   <= WIDTH'(sat_inc(32'(errors), 32'(ERR_MAX)));
                            last_bad <= sIn;
                        end
                        expected <= next_expected;
                        count    <= count + WIDTH'(1);
                        if (count == LAST_IDX) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_seq_check.sv
// Bench for stream_seq_check: two instances (patterns 1111 and 1010) share
// one set of stimulus variables, gated by use_b. A reference model derives
// results from the item list; a monitor checks results on consumption.
module tb_stream_seq_check;

    localparam int         W     = 8;
    localparam int         COUNT = 16;
    localparam logic [3:0] PAT_A = 4'b1111;
    localparam logic [3:0] PAT_B = 4'b1010;

    typedef struct {
        logic [W-1:0] cnt;
        logic [W-1:0] err;
        logic [W-1:0] bad;
    } res_t;

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic         use_b = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] first = '0;
    logic [W-1:0] sIn = '0;
    logic         sIn_valid = 1'b0;
    logic         out_ready = 1'b0;

    logic         a_in_ready, a_sIn_ready, a_out_valid;
    logic [W-1:0] a_count, a_errors, a_last_bad;
    logic         b_in_ready, b_sIn_ready, b_out_valid;
    logic [W-1:0] b_count, b_errors, b_last_bad;

    logic         cur_in_ready, cur_sIn_ready, cur_out_valid;
    logic [W-1:0] cur_count, cur_errors, cur_last_bad;

    int           vectors = 0;
    int           miscompares = 0;
    res_t         sb[$];
    logic [W-1:0] stim[COUNT];

    always #5 clk = ~clk;

    stream_seq_check #(.WIDTH(W), .COUNT(COUNT), .STALL_PATTERN(PAT_A)) dut_a (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid & ~use_b),
        .in_ready  (a_in_ready),
        .first     (first),
        .sIn       (sIn),
        .sIn_valid (sIn_valid & ~use_b),
        .sIn_ready (a_sIn_ready),
        .out_valid (a_out_valid),
        .out_ready (out_ready & ~use_b),
        .count     (a_count),
        .errors    (a_errors),
        .last_bad  (a_last_bad)
    );

    stream_seq_check #(.WIDTH(W), .COUNT(COUNT), .STALL_PATTERN(PAT_B)) dut_b (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid & use_b),
        .in_ready  (b_in_ready),
        .first     (first),
        .sIn       (sIn),
        .sIn_valid (sIn_valid & use_b),
        .sIn_ready (b_sIn_ready),
        .out_valid (b_out_valid),
        .out_ready (out_ready & use_b),
        .count     (b_count),
        .errors    (b_errors),
        .last_bad  (b_last_bad)
    );

    assign cur_in_ready  = use_b ? b_in_ready  : a_in_ready;
    assign cur_sIn_ready = use_b ? b_sIn_ready : a_sIn_ready;
    assign cur_out_valid = use_b ? b_out_valid : a_out_valid;
    assign cur_count     = use_b ? b_count     : a_count;
    assign cur_errors    = use_b ? b_errors    : a_errors;
    assign cur_last_bad  = use_b ? b_last_bad  : a_last_bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: a run's error count is the number of items that differ from
    // their reference value; the last such item is last_bad.
    function automatic res_t model(input logic [W-1:0] f);
        res_t         r;
        logic [W-1:0] ref_v;
        r.cnt = W'(COUNT);
        r.err = '0;
        r.bad = '0;
        for (int i = 0; i < COUNT; i++) begin
`ifdef STREAM_SEQ_CHECK_RESYNC_EN
            if (i == 0) ref_v = f;
            else        ref_v = W'(stim[i-1] + 1);
`else
            ref_v = W'(f + i);
`endif
            if (stim[i] != ref_v) begin
                if (r.err != '1) r.err = r.err + 1'b1;
                r.bad = stim[i];
            end
        end
        return r;
    endfunction

    // Cycles an always-valid source needs: slots elapse until COUNT ready slots have passed.
    function automatic int cycles_needed(input logic [3:0] pat);
        int t = 0;
        int got = 0;
        while (got < COUNT) begin
            if (pat[t % 4]) got++;
            t++;
        end
        return t;
    endfunction

    // kind 0 clean, 1 skipped item, 2 inserted item, 3 sparse corruption
    task automatic make_stim(input logic [W-1:0] f, input int kind);
        int k = $urandom_range(1, COUNT - 2);
        for (int i = 0; i < COUNT; i++) begin
            case (kind)
                1:       stim[i] = W'(f + i + ((i >= k) ? 1 : 0));
                2:       stim[i] = (i < k) ? W'(f + i) : (i == k) ? W'($urandom) : W'(f + i - 1);
                3:       stim[i] = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'(f + i);
                default: stim[i] = W'(f + i);
            endcase
        end
    endtask

    // Scoreboard monitor: results are compared whenever the DUT's result is consumed.
    always @(negedge clk) begin
        if (nrst && cur_out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                res_t e;
                e = sb.pop_front();
                chk("mon_count",    32'(cur_count),    32'(e.cnt));
                chk("mon_errors",   32'(cur_errors),   32'(e.err));
                chk("mon_last_bad", 32'(cur_last_bad), 32'(e.bad));
            end
        end
    end

    // Enters and leaves at posedge+1. abort_at > 0 stops after that many handshakes.
    task automatic do_run(input logic [W-1:0] f, input int pct, input int hold, input int abort_at);
        res_t       e;
        logic [3:0] pat;
        int         idx = 0;
        int         cycles = 0;
        logic       hs;
        pat = use_b ? PAT_B : PAT_A;
        e = model(f);
        sb.push_back(e);

        in_valid = 1'b1;
        first    = f;
        @(negedge clk);
        chk("idle_in_ready", 32'(cur_in_ready), 32'd1);
        chk("idle_sIn_ready", 32'(cur_sIn_ready), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        first    = W'($urandom);

        while (idx < COUNT && !(abort_at > 0 && idx == abort_at)) begin
            sIn       = stim[idx];
            sIn_valid = ($urandom_range(1, 100) <= pct);
            in_valid  = $urandom_range(0, 1) == 1;
            @(negedge clk);
            chk("run_sIn_ready", 32'(cur_sIn_ready), 32'(pat[cycles % 4]));
            chk("run_out_valid", 32'(cur_out_valid), 32'd0);
            hs = sIn_valid && cur_sIn_ready;
            @(posedge clk); #1;
            if (hs) idx++;
            cycles++;
            if (cycles > 2000) begin
                chk("run_timeout", 32'(idx), 32'(COUNT));
                break;
            end
        end
        sIn_valid = 1'b0;
        in_valid  = 1'b0;
        if (abort_at > 0) begin
            void'(sb.pop_back());
            return;
        end
        if (pct >= 100) chk("run_cycles", 32'(cycles), 32'(cycles_needed(pat)));

        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_out_valid", 32'(cur_out_valid), 32'd1);
            chk("hold_sIn_ready", 32'(cur_sIn_ready), 32'd0);
            chk("hold_count",     32'(cur_count),     32'(e.cnt));
            chk("hold_errors",    32'(cur_errors),    32'(e.err));
            chk("hold_last_bad",  32'(cur_last_bad),  32'(e.bad));
            @(posedge clk); #1;
        end

        // Consume results while also requesting a start, which must not be taken.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        chk("done_out_valid", 32'(cur_out_valid), 32'd1);
        chk("done_in_ready",  32'(cur_in_ready),  32'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        chk("after_in_ready",  32'(cur_in_ready),  32'd1);
        chk("after_out_valid", 32'(cur_out_valid), 32'd0);
        chk("after_sIn_ready", 32'(cur_sIn_ready), 32'd0);
        chk("after_count",     32'(cur_count),     32'(e.cnt));
        chk("after_errors",    32'(cur_errors),    32'(e.err));
        @(posedge clk); #1;
    endtask

    task automatic reset_checks(input string tag);
        @(negedge clk);
        chk({tag, "_in_ready"},  32'(cur_in_ready),  32'd1);
        chk({tag, "_sIn_ready"}, 32'(cur_sIn_ready), 32'd0);
        chk({tag, "_out_valid"}, 32'(cur_out_valid), 32'd0);
        chk({tag, "_count"},     32'(cur_count),     32'd0);
    endtask

    initial begin
        logic [W-1:0] f;
        nrst = 1'b0;
        reset_checks("rst");
        chk("rst_errors",   32'(cur_errors),   32'd0);
        chk("rst_last_bad", 32'(cur_last_bad), 32'd0);
        chk("rst_b_in_ready", 32'(b_in_ready), 32'd1);
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;

        // Pattern 1010 instance, always-valid counter source.
        use_b = 1'b1;
        f = W'($urandom);
        make_stim(f, 0);
        do_run(f, 100, 2, 0);
        use_b = 1'b0;

        // Clean counter from 0, always valid: exactly COUNT run cycles.
        make_stim('0, 0);
        do_run('0, 100, 0, 0);

        // Source skips 6 with results held in DONE for 5 cycles.
        for (int i = 0; i < COUNT; i++) stim[i] = W'((i < 6) ? i : i + 1);
        do_run('0, 70, 5, 0);

        // Wrap-around from 250.
        make_stim(8'd250, 0);
        do_run(8'd250, 80, 1, 0);

        // Reset after 5 handshakes discards the run; a new one then runs cleanly.
        make_stim(8'd40, 0);
        do_run(8'd40, 100, 0, 5);
        nrst = 1'b0;
        reset_checks("mid_rst");
        @(posedge clk); #1;
        reset_checks("mid_rst_hold");
        nrst = 1'b1;
        @(posedge clk); #1;
        reset_checks("post_rst");
        @(posedge clk); #1;
        make_stim(8'd40, 0);
        do_run(8'd40, 90, 0, 0);

        // Randomized runs.
        for (int r = 0; r < 12; r++) begin
            f = W'($urandom);
            make_stim(f, $urandom_range(0, 3));
            do_run(f, $urandom_range(30, 100), $urandom_range(0, 5), 0);
        end

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stream_seq_check.md
# stream_seq_check

Stream receiver that sits on the consuming end of a `stream` valid/ready channel. It accepts a fixed number of items, checks them against an incrementing reference sequence, and applies a programmable back-pressure pattern on `sIn_ready`. Results are reported through the standard `in_valid`/`out_ready` sync handshake. It serves as the sink counterpart to the counter-source stimulus used in the generated-module benches, and is also usable in-fabric as a stream monitor.

## Interface
- `WIDTH`, default `` `intN ``: item width and counter width.
- `COUNT`, default 16: items consumed per run; legal range 1..2^WIDTH.
- `STALL_PATTERN`, default 4'b1111: back-pressure pattern; bit i = 0 drops ready on slot i.
- `clk`  in  1  clock, rising edge.
- `nrst`  in  1  reset; asynchronous assert, active-low.
- `in_valid`  in  1  start request; captures `first`.
- `in_ready`  out  1  high when idle; start is accepted.
- `first`  in  WIDTH  expected value of the first item.
- `sIn`  in  WIDTH  stream data.
- `sIn_valid`  in  1  stream data valid.
- `sIn_ready`  out  1  stream ready (back-pressure).
- `out_valid`  out  1  results valid.
- `out_ready`  in  1  results consumed.
- `count`  out  WIDTH  items accepted in the current or last run.
- `errors`  out  WIDTH  mismatch count; saturates at 2^WIDTH-1.
- `last_bad`  out  WIDTH  most recent mismatching `sIn` value.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: `expected`<=`first`, `count`<=0, `errors`<=0, `last_bad`<=0, pattern slot<=0; go to RUN.
- RUN:
  - `sIn_ready` = `STALL_PATTERN[slot]`.
  - The slot advances modulo 4 every RUN cycle, whether or not a transfer occurs.
  - A handshake is `sIn_valid && sIn_ready`. On each handshake:
    - compare `sIn` with `expected`;
    - on mismatch, `errors`++ (saturating) and `last_bad`<=`sIn`;
    - `expected`<=`expected`+1, wrapping modulo 2^WIDTH;
    - `count`++.
  - The handshake with `count`==COUNT-1 moves to DONE.
  - `in_valid` is ignored in RUN.
- DONE:
  - `out_valid`=1 and `sIn_ready`=0.
  - `count`, `errors` and `last_bad` are held stable.
  - On `out_ready`, go to IDLE. Result registers keep their values until the next start.
- If `STALL_PATTERN` is 0, the run never completes. This is legal, and the bench must not use it.

## Timing
- Reset values: `in_ready`=1, `sIn_ready`=0, `out_valid`=0, `count`=0, `errors`=0, `last_bad`=0; state IDLE.
- `sIn_ready`, `in_ready` and `out_valid` decode from registered state and slot only. There is no combinational path from any input.
- Start accepted at edge N means `sIn_ready` is first possible in cycle N+1.
- Final handshake at edge M means `out_valid`=1 in cycle M+1.
- With pattern 4'b1111 and a source that is always valid, a run takes exactly COUNT RUN cycles.
- DONE with `out_ready` and `in_valid` high in the same cycle: return to IDLE only. The start is not accepted, because `in_ready`=0 in DONE.
- Reset during RUN or DONE: immediate return to reset values. Any partial run is discarded.

## Configuration
- `STREAM_SEQ_CHECK_RESYNC_EN` defined: on a mismatch, `expected`<=`sIn`+1, so a dropped or inserted item costs one error.
- Not defined: `expected` always advances from its previous value, so every item after a slip counts as an error.

## Structure
- Shared defines header, alongside `primitives.v`, holds:
  - state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the saturating-increment macro.
- One sub-module, `stream_stall_gen`:
  - 2-bit slot counter plus pattern mux;
  - inputs `clk`, `nrst`, `run` and `restart`; output `ready`.
- Top level contains the FSM, comparator and counters.

## Test plan
- First=0, pattern 1111, counter source 0,1,2,… → `out_valid` one cycle after the 16th handshake, `count`=16, `errors`=0.
- Pattern 4'b1010 → `sIn_ready` alternates 1,0. Run completes in 32 RUN cycles with `errors`=0.
- Source skips 6 (…5,7,8,…,16) → with RESYNC_EN, `errors`=1 and `last_bad`=7. Without RESYNC_EN, `errors`=10 and `last_bad`=16.
- First=250, WIDTH=8, source 250..255 then 0..9 → `errors`=0 and `count`=16; wrap-around is not flagged.
- `out_ready` held low for 5 cycles in DONE → `out_valid` and the results are held, and `sIn_ready`=0 throughout. Raising `in_valid` in the same cycle as `out_ready` is not accepted.
- `nrst` pulsed low after 5 handshakes → `in_ready`=1, `sIn_ready`=0, `count`=0 during and after the pulse. A new start then runs cleanly.
